// File: rtl/vx_bar_pkg.sv
// Shared types and width constants for the barrier controller and its entries.
package vx_bar_pkg;

    localparam int BAR_NUM_WARPS    = 4;
    localparam int BAR_NUM_BARRIERS = 4;
    localparam int NW_WIDTH = (BAR_NUM_WARPS > 1) ? $clog2(BAR_NUM_WARPS) : 1;
    localparam int NB_WIDTH = (BAR_NUM_BARRIERS > 1) ? $clog2(BAR_NUM_BARRIERS) : 1;

    // Architectural state of one barrier ID.
    typedef struct packed {
        logic [NW_WIDTH-1:0]      count;
        logic [NW_WIDTH-1:0]      size_m1;
        logic [BAR_NUM_WARPS-1:0] wmask;
    } bar_state_t;

endpackage

// File: rtl/vx_barrier_entry.sv
// One barrier ID: tracks waiting warps, latches the participant count on the
// first arrival and flags final / duplicate / size-mismatch requests.
module vx_barrier_entry
    import vx_bar_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sel,
    input  logic [NW_WIDTH-1:0]      req_wid,
    input  logic [NW_WIDTH-1:0]      req_size_m1,
    output logic [NW_WIDTH-1:0]      count,
    output logic [BAR_NUM_WARPS-1:0] wmask,
    output logic                     hit_final,
    output logic                     dup,
    output logic                     size_err
);

    bar_state_t          state_reg;
    logic [NW_WIDTH-1:0] eff_size;

    // Classify the incoming request; a duplicate masks every other effect.
    always_comb begin
        dup       = sel && state_reg.wmask[req_wid];
        eff_size  = (state_reg.count == '0) ? req_size_m1 : state_reg.size_m1;
        size_err  = sel && !dup && (state_reg.count != '0) &&
                    (req_size_m1 != state_reg.size_m1);
        hit_final = sel && !dup && (state_reg.count == eff_size);
    end

    // Arrival bookkeeping: the final arriver clears the barrier instead of waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= '0;
        end else if (sel && !dup) begin
            if (state_reg.count == '0) begin
                state_reg.size_m1 <= req_size_m1;
            end
            if (hit_final) begin
                state_reg.count <= '0;
                state_reg.wmask <= '0;
            end else begin
                state_reg.count          <= NW_WIDTH'(state_reg.count + 1'b1);
                state_reg.wmask[req_wid] <= 1'b1;
            end
        end
    end

    assign count = state_reg.count;
    assign wmask = state_reg.wmask;

endmodule

// File: rtl/vx_barrier_ctl.sv
// Barrier arrival tracker: routes requests to per-ID entries, merges their
// waiting masks into the scheduler stall mask and registers release/error pulses.
module vx_barrier_ctl
    import vx_bar_pkg::*;
#(
    parameter int NUM_WARPS    = BAR_NUM_WARPS,
    parameter int NUM_BARRIERS = BAR_NUM_BARRIERS
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   req_valid,
    input  logic [NW_WIDTH-1:0]                    req_wid,
    input  logic [NB_WIDTH-1:0]                    req_bar_id,
    input  logic [NW_WIDTH-1:0]                    req_size_m1,
    output logic [NUM_WARPS-1:0]                   stall_mask,
    output logic                                   release_valid,
    output logic [NB_WIDTH-1:0]                    release_bar_id,
    output logic [NUM_WARPS-1:0]                   release_mask,
    output logic [NUM_BARRIERS-1:0][NW_WIDTH-1:0]  bar_ctrs,
    output logic                                   err_dup,
    output logic                                   err_size
);

    logic [NUM_BARRIERS-1:0] ent_sel;
    logic [NUM_BARRIERS-1:0] ent_final;
    logic [NUM_BARRIERS-1:0] ent_dup;
    logic [NUM_BARRIERS-1:0] ent_serr;
    logic [NW_WIDTH-1:0]     ent_count [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    ent_wmask [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    release_mask_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BARRIERS; gi++) begin : g_entry
            assign ent_sel[gi] = req_valid && (req_bar_id == NB_WIDTH'(gi));

            vx_barrier_entry u_entry (
                .clk         (clk),
                .reset_n     (reset_n),
                .sel         (ent_sel[gi]),
                .req_wid     (req_wid),
                .req_size_m1 (req_size_m1),
                .count       (ent_count[gi]),
                .wmask       (ent_wmask[gi]),
                .hit_final   (ent_final[gi]),
                .dup         (ent_dup[gi]),
                .size_err    (ent_serr[gi])
            );
        end
    endgenerate

    // Stall mask is the union of all waiting sets; counters come straight from the entries.
    always_comb begin
        stall_mask = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            stall_mask  = stall_mask | ent_wmask[b];
            bar_ctrs[b] = ent_count[b];
        end
    end

    // Released set is everyone already waiting plus the final arriver.
    assign release_mask_next = ent_wmask[req_bar_id] | (NUM_WARPS'(1) << req_wid);

    // Register the one-cycle pulses; release ID/mask hold between completions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            release_valid  <= 1'b0;
            release_bar_id <= '0;
            release_mask   <= '0;
            err_dup        <= 1'b0;
            err_size       <= 1'b0;
        end else begin
            release_valid <= |ent_final;
            err_dup       <= |ent_dup;
            err_size      <= |ent_serr;
            if (|ent_final) begin
                release_bar_id <= req_bar_id;
                release_mask   <= release_mask_next;
            end
        end
    end

endmodule

// File: tb/tb_vx_barrier_ctl.sv
// Bench for vx_barrier_ctl: directed vector table, reset sequence and random
// traffic, all compared against a set-based barrier model.
module tb_vx_barrier_ctl;
    import vx_bar_pkg::*;

    localparam int NWARP = BAR_NUM_WARPS;
    localparam int NBAR  = BAR_NUM_BARRIERS;

    logic                              clk;
    logic                              reset_n;
    logic                              req_valid;
    logic [NW_WIDTH-1:0]               req_wid;
    logic [NB_WIDTH-1:0]               req_bar_id;
    logic [NW_WIDTH-1:0]               req_size_m1;
    logic [NWARP-1:0]                  stall_mask;
    logic                              release_valid;
    logic [NB_WIDTH-1:0]               release_bar_id;
    logic [NWARP-1:0]                  release_mask;
    logic [NBAR-1:0][NW_WIDTH-1:0]     bar_ctrs;
    logic                              err_dup;
    logic                              err_size;

    vx_barrier_ctl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_wid        (req_wid),
        .req_bar_id     (req_bar_id),
        .req_size_m1    (req_size_m1),
        .stall_mask     (stall_mask),
        .release_valid  (release_valid),
        .release_bar_id (release_bar_id),
        .release_mask   (release_mask),
        .bar_ctrs       (bar_ctrs),
        .err_dup        (err_dup),
        .err_size       (err_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: set of waiting warps and agreed size per barrier.
    logic [NWARP-1:0] m_wait [NBAR];
    int               m_size [NBAR];
    logic             e_rv, e_dup, e_serr;
    int               e_rbid;
    logic [NWARP-1:0] e_rmask;

    typedef struct {
        logic v; int w; int b; int s;
        logic [NWARP-1:0] stall; logic rv; int rbid;
        logic [NWARP-1:0] rmask; int ctr; logic dup; logic serr;
    } vec_t;
    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NWARP-1:0] m_stall();
        logic [NWARP-1:0] s = '0;
        for (int b = 0; b < NBAR; b++) s |= m_wait[b];
        return s;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NBAR; b++) begin
            m_wait[b] = '0;
            m_size[b] = 0;
        end
    endtask

    task automatic model_req(input logic v, input int w, input int b, input int s);
        int cnt;
        e_rv = 0; e_dup = 0; e_serr = 0; e_rbid = 0; e_rmask = '0;
        if (v) begin
            if (m_wait[b][w]) begin
                e_dup = 1;
            end else begin
                cnt = $countones(m_wait[b]);
                if (cnt == 0) m_size[b] = s;
                else if (s != m_size[b]) e_serr = 1;
                if (cnt == m_size[b]) begin
                    e_rv = 1; e_rbid = b;
                    e_rmask = m_wait[b] | (NWARP'(1) << w);
                    m_wait[b] = '0;
                end else begin
                    m_wait[b][w] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_model();
        check("stall_mask", 32'(stall_mask), 32'(m_stall()));
        check("release_valid", 32'(release_valid), 32'(e_rv));
        if (e_rv) begin
            check("release_bar_id", 32'(release_bar_id), 32'(e_rbid));
            check("release_mask", 32'(release_mask), 32'(e_rmask));
        end
        check("err_dup", 32'(err_dup), 32'(e_dup));
        check("err_size", 32'(err_size), 32'(e_serr));
        for (int b = 0; b < NBAR; b++)
            check($sformatf("bar_ctrs[%0d]", b), 32'(bar_ctrs[b]), $countones(m_wait[b]));
    endtask

    // Drive one cycle of stimulus at the falling edge, check just after the rising edge.
    task automatic apply(input logic v, input int w, input int b, input int s);
        req_valid   = v;
        req_wid     = NW_WIDTH'(w);
        req_bar_id  = NB_WIDTH'(b);
        req_size_m1 = NW_WIDTH'(s);
        @(posedge clk);
        #1;
        model_req(v, w, b, s);
        $display("req v=%0d w=%0d b=%0d s=%0d -> stall=%b rv=%0d rb=%0d rm=%b dup=%0d serr=%0d",
                 v, w, b, s, stall_mask, release_valid, release_bar_id, release_mask, err_dup, err_size);
        compare_model();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic add(input logic v, input int w, input int b, input int s,
                       input logic [NWARP-1:0] stall, input logic rv, input int rbid,
                       input logic [NWARP-1:0] rmask, input int ctr, input logic dup, input logic serr);
        vec_t t;
        t.v = v; t.w = w; t.b = b; t.s = s; t.stall = stall; t.rv = rv; t.rbid = rbid;
        t.rmask = rmask; t.ctr = ctr; t.dup = dup; t.serr = serr;
        vecs.push_back(t);
    endtask

    task automatic pulse_reset_and_check();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_stall_async", 32'(stall_mask), 32'd0);
        check("rst_ctrs_async", 32'(bar_ctrs), 32'd0);
        check("rst_rv_async", 32'(release_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rst_rv_held", 32'(release_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset pulse applied");
    endtask

    initial begin
        int w, b, s, r;
        logic [NWARP-1:0] busy;

        reset_n = 1'b0; req_valid = 0; req_wid = '0; req_bar_id = '0; req_size_m1 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_stall", 32'(stall_mask), 32'd0);
        check("reset_rv", 32'(release_valid), 32'd0);
        check("reset_rbid", 32'(release_bar_id), 32'd0);
        check("reset_rmask", 32'(release_mask), 32'd0);
        check("reset_ctrs", 32'(bar_ctrs), 32'd0);
        check("reset_errs", {30'd0, err_dup, err_size}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // v w b s | stall rv rbid rmask ctr(b) dup serr
        add(1, 0, 1, 3, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        add(1, 1, 1, 3, 4'b0011, 0, 0, 4'b0000, 2, 0, 0);
        add(1, 2, 1, 3, 4'b0111, 0, 0, 4'b0000, 3, 0, 0);
        add(0, 0, 1, 0, 4'b0111, 0, 0, 4'b0000, 3, 0, 0);
        add(0, 0, 1, 0, 4'b0111, 0, 0, 4'b0000, 3, 0, 0);
        add(1, 3, 1, 3, 4'b0000, 1, 1, 4'b1111, 0, 0, 0);
        add(1, 2, 0, 0, 4'b0000, 1, 0, 4'b0100, 0, 0, 0);
        add(1, 0, 2, 1, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        add(1, 0, 2, 1, 4'b0001, 0, 0, 4'b0000, 1, 1, 0);
        add(1, 1, 2, 1, 4'b0000, 1, 2, 4'b0011, 0, 0, 0);
        add(1, 0, 3, 1, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        add(1, 1, 3, 2, 4'b0000, 1, 3, 4'b0011, 0, 0, 1);
        add(1, 0, 0, 1, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        add(1, 2, 1, 1, 4'b0101, 0, 0, 4'b0000, 1, 0, 0);
        add(1, 1, 0, 1, 4'b0100, 1, 0, 4'b0011, 0, 0, 0);
        add(1, 3, 1, 1, 4'b0000, 1, 1, 4'b1100, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].w, vecs[i].b, vecs[i].s);
            check($sformatf("vec%0d_stall", i), 32'(stall_mask), 32'(vecs[i].stall));
            check($sformatf("vec%0d_rv", i), 32'(release_valid), 32'(vecs[i].rv));
            if (vecs[i].rv) begin
                check($sformatf("vec%0d_rbid", i), 32'(release_bar_id), 32'(vecs[i].rbid));
                check($sformatf("vec%0d_rmask", i), 32'(release_mask), 32'(vecs[i].rmask));
            end
            check($sformatf("vec%0d_ctr", i), 32'(bar_ctrs[vecs[i].b]), 32'(vecs[i].ctr));
            check($sformatf("vec%0d_dup", i), 32'(err_dup), 32'(vecs[i].dup));
            check($sformatf("vec%0d_serr", i), 32'(err_size), 32'(vecs[i].serr));
        end

        // Reset while three warps wait on barrier 1, then a fresh barrier.
        apply(1, 0, 1, 3);
        apply(1, 1, 1, 3);
        apply(1, 2, 1, 3);
        check("pre_rst_stall", 32'(stall_mask), 32'b0111);
        check("pre_rst_ctr1", 32'(bar_ctrs[1]), 32'd3);
        pulse_reset_and_check();
        apply(1, 3, 2, 1);
        apply(1, 0, 2, 1);
        check("post_rst_rv", 32'(release_valid), 32'd1);
        check("post_rst_rmask", 32'(release_mask), 32'b1001);

        // Random legal traffic, with occasional duplicates and size mismatches.
        for (int i = 0; i < 400; i++) begin
            busy = m_stall();
            r = $urandom_range(0, 9);
            if (busy == '1) begin
                pulse_reset_and_check();
            end else if (r == 0) begin
                apply(0, 0, 0, 0);
            end else if (r == 1 && busy != '0) begin
                do w = $urandom_range(0, NWARP - 1); while (!busy[w]);
                b = 0;
                for (int k = 0; k < NBAR; k++) if (m_wait[k][w]) b = k;
                apply(1, w, b, $urandom_range(0, NWARP - 1));
            end else begin
                do w = $urandom_range(0, NWARP - 1); while (busy[w]);
                b = $urandom_range(0, NBAR - 1);
                if (m_wait[b] != '0 && $urandom_range(0, 3) != 0) s = m_size[b];
                else s = $urandom_range(0, NWARP - 1);
                apply(1, w, b, s);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
